xlr_mac_seq: RTL and testbench
==============================

# xlr_mac_seq

Sequencer for the accelerator's MAC datapath: the eight 4-byte dot-product lanes and their vector register file.
- On a host go pulse, walks a matrix A (in MEM0) row by row against a vector B (in MEM1), one 32-byte line per beat.
- Drives XBOX memory reads, lane accumulate enables and accumulator clears.
- Writes each row's eight 32-bit lane sums back to memory.
- Sits between the host-register decode and the dot-product/register-file datapath, replacing ad-hoc counter logic in the accelerator top.

## Interface
Parameters:
- LOG2_LINES_PER_MEM, 4: line-address width per memory.
- NUM_LANES, 8: dot-product lanes; each lane covers 4 bytes of a line.

Ports:
- clk  in  1  system clock.
- sync_rst  in  1  reset; one clock, synchronous, active-high.
- go  in  1  start pulse (host GO bit AND valid pulse).
- cfg_rows  in  16  rows of A.
- cfg_cols  in  16  bytes per row.
- cfg_addr_a, cfg_addr_b, cfg_addr_res  in  LOG2_LINES_PER_MEM each  base line addresses.
- mem_addr  out  [1:0][LOG2_LINES_PER_MEM-1:0]  line address; index 0 = MEM0, 1 = MEM1.
- mem_rd  out  [1:0]  read strobes.
- mem_wr  out  [1:0]  write strobes; only [0] is ever used.
- mem_be  out  32  byte enables for the write.
- acc_clr  out  1  synchronous clear of the lane accumulators.
- lane_en  out  NUM_LANES  per-lane accumulate enable.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle config-error pulse, coincident with done.
- perf_cycles  out  32  busy-cycle count (see Configuration).

## Operation
- States: IDLE, CLR, RD, DRAIN, WB, FIN.
- IDLE:
  - go latches all cfg_* inputs.
  - If cfg_rows==0 or cfg_cols==0, go to FIN with err set; otherwise go to CLR.
  - go while not in IDLE is ignored.
- Beats per row: k = ceil(cfg_cols/32), computed at latch.
- CLR: acc_clr=1 for one cycle, then RD.
- RD: runs k cycles, beat b = 0..k-1.
  - mem_rd = 2'b11.
  - mem_addr[0] = addr_a + row*k + b.
  - mem_addr[1] = addr_b + b.
  - After the last beat, go to DRAIN.
- Lane enables:
  - Memory read latency is 1 cycle, so lane_en for beat b is asserted in the cycle after beat b's read (the next RD cycle, or DRAIN).
  - mask = min(32, cfg_cols − 32*b); lane_en[i] = (4*i < mask).
  - lane_en is 0 in all other cycles.
- DRAIN: one cycle carrying the last beat's lane_en, then WB.
- WB:
  - mem_wr[0]=1, mem_addr[0] = addr_res + row, mem_be = 32'hFFFF_FFFF.
  - The datapath supplies the write data.
  - Next state: CLR for the next row, or FIN after the last row.
- FIN: done=1 (plus err if flagged) for one cycle, then IDLE.
- Address arithmetic is modulo 2^LOG2_LINES_PER_MEM (silent wrap); row*k is computed at full width, then truncated.
- busy = (state != IDLE).
- Strobes, acc_clr and lane_en are 0 in any state not listed for them.

## Timing
- All outputs are registered.
- Reset value: every output is 0; state = IDLE.
- go sampled at edge T:
  - CLR is visible in cycle T+1.
  - First read in T+2.
- Per-row cost: k+3 cycles. Total busy cycles = rows*(k+3) + 1 (FIN).
- Config-error path: go at T, then FIN (done=err=1) in T+1; no memory strobe at any point.
- sync_rst mid-operation:
  - Next cycle: IDLE with all outputs 0.
  - No done pulse is produced.
  - Latched cfg is discarded.
- go in the same cycle as sync_rst is ignored.
- go in the FIN cycle is ignored; go on the first IDLE cycle after FIN is accepted.

## Configuration
- Macro: XLR_MAC_SEQ_PERF_CNT_EN.
- Defined:
  - perf_cycles clears on an accepted go and increments every busy cycle.
  - It holds its value after FIN until the next go, saturates at 32'hFFFF_FFFF, and resets to 0.
- Undefined: perf_cycles is tied to 0 and no counter is synthesized.

## Test plan
- rows=1, cols=32, a=2, b=5, res=9, go at T:
  - acc_clr at T+1.
  - RD at T+2 with addresses (2,5).
  - lane_en=0xFF at T+3.
  - WB at T+4: mem_addr[0]=9, be=all ones.
  - done at T+5, err=0.
- rows=2, cols=40 (k=2):
  - MEM0 reads at 0,1 then 2,3; MEM1 reads at 0,1 each row.
  - lane_en per row: 0xFF then 0x03.
  - Writes at res, res+1.
  - 11 busy cycles.
- cols=0 or rows=0: done=err=1 at T+1; mem_rd and mem_wr stay 0 throughout.
- Address wrap: LOG2=4, a=15, b=15, rows=1, cols=64 → reads at line 15 then line 0 on both ports.
- Abort and restart:
  - sync_rst during the second RD beat → all outputs 0 next cycle, no done.
  - A subsequent go completes normally.
  - A go issued while busy is ignored, with no change to the address sequence.
- With XLR_MAC_SEQ_PERF_CNT_EN defined: rows=2, cols=40 → perf_cycles=11 after done. Without the macro: 0.

Source files
------------

// File: rtl/xlr_mac_seq.sv
// -----------------------------------------------------------------------------
// xlr_mac_seq
//
// Sequencer for the MAC datapath: eight 4-byte dot-product lanes plus their
// vector register file. A go pulse walks matrix A (MEM0) row by row against
// vector B (MEM1), one 32-byte line per beat. The sequencer drives the memory
// reads, per-lane accumulate enables and accumulator clears, and writes each
// row's lane sums back to MEM0.
//
// Optional feature macro: XLR_MAC_SEQ_PERF_CNT_EN
//   defined   : perf_cycles counts busy cycles of the last accepted operation
//               (cleared on go, saturating).
//   undefined : perf_cycles is tied to 0 and no counter is built.
//
// Ports
//   clk           in   system clock
//   sync_rst      in   synchronous active-high reset
//   go            in   start pulse, accepted only in IDLE
//   cfg_rows      in   rows of A
//   cfg_cols      in   bytes per row
//   cfg_addr_a    in   base line of A in MEM0
//   cfg_addr_b    in   base line of B in MEM1
//   cfg_addr_res  in   base line of the results in MEM0
//   mem_addr      out  line address per memory (0 = MEM0, 1 = MEM1)
//   mem_rd        out  read strobes per memory
//   mem_wr        out  write strobes per memory (only MEM0 is written)
//   mem_be        out  byte enables for the write
//   acc_clr       out  clear of the lane accumulators
//   lane_en       out  per-lane accumulate enable
//   busy          out  operation in progress
//   done          out  one-cycle completion pulse
//   err           out  one-cycle config-error pulse, coincident with done
//   perf_cycles   out  busy-cycle count of the last operation
//
// States
//   state | meaning
//   IDLE  | waiting for go; cfg latched when go is accepted
//   CLR   | clear lane accumulators before a row
//   RD    | one line read per beat from both memories, k beats per row
//   DRAIN | lane enables for the last beat (read latency of one cycle)
//   WB    | write the row's lane sums to MEM0
//   FIN   | done pulse (with err on a bad config), then back to IDLE
// -----------------------------------------------------------------------------
module xlr_mac_seq #(
  parameter int LOG2_LINES_PER_MEM = 4,
  parameter int NUM_LANES          = 8
) (
  input  logic                                 clk,
  input  logic                                 sync_rst,
  input  logic                                 go,
  input  logic [15:0]                          cfg_rows,
  input  logic [15:0]                          cfg_cols,
  input  logic [LOG2_LINES_PER_MEM-1:0]        cfg_addr_a,
  input  logic [LOG2_LINES_PER_MEM-1:0]        cfg_addr_b,
  input  logic [LOG2_LINES_PER_MEM-1:0]        cfg_addr_res,
  output logic [1:0][LOG2_LINES_PER_MEM-1:0]   mem_addr,
  output logic [1:0]                           mem_rd,
  output logic [1:0]                           mem_wr,
  output logic [31:0]                          mem_be,
  output logic                                 acc_clr,
  output logic [NUM_LANES-1:0]                 lane_en,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [31:0]                          perf_cycles
);

  localparam int AW = LOG2_LINES_PER_MEM;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RD,
    DRAIN,
    WB,
    FIN
  } state_t;

  state_t          state;

  logic [15:0]     rows_left;
  logic [15:0]     cols_lat;
  logic [11:0]     k_beats;
  logic [11:0]     beats_left;
  logic [15:0]     rem;
  logic [AW-1:0]   ptr_a;
  logic [AW-1:0]   ptr_b;
  logic [AW-1:0]   base_b;
  logic [AW-1:0]   ptr_res;

  logic [11:0]     k_calc;
  logic            cfg_bad;
  logic [15:0]     rem_min;
  logic [NUM_LANES-1:0] beat_mask;

  // Beats per row, ceil(cols/32); 2048 is the largest value and fits 12 bits.
  assign k_calc  = 12'((32'(cfg_cols) + 32'd31) >> 5);
  assign cfg_bad = (cfg_rows == 16'd0) || (cfg_cols == 16'd0);

  // rem holds the bytes of the row not yet consumed at the current beat;
  // a lane is enabled when its first byte falls inside the valid part.
  always_comb begin
    rem_min   = (rem > 16'd32) ? 16'd32 : rem;
    beat_mask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      beat_mask[i] = (32'(rem_min) > 32'(4 * i));
    end
  end

  // A's line address addr_a + row*k + b is contiguous across rows, so a
  // single running pointer replaces the row*k product; wrap is implicit in
  // the pointer width.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state      <= IDLE;
      rows_left  <= '0;
      cols_lat   <= '0;
      k_beats    <= '0;
      beats_left <= '0;
      rem        <= '0;
      ptr_a      <= '0;
      ptr_b      <= '0;
      base_b     <= '0;
      ptr_res    <= '0;
      mem_addr   <= '0;
      mem_rd     <= '0;
      mem_wr     <= '0;
      mem_be     <= '0;
      acc_clr    <= 1'b0;
      lane_en    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      acc_clr  <= 1'b0;
      lane_en  <= '0;
      mem_rd   <= '0;
      mem_wr   <= '0;
      mem_be   <= '0;
      mem_addr <= '0;
      done     <= 1'b0;
      err      <= 1'b0;

      unique case (state)
        IDLE: begin
          if (go) begin
            busy      <= 1'b1;
            rows_left <= cfg_rows;
            cols_lat  <= cfg_cols;
            k_beats   <= k_calc;
            ptr_a     <= cfg_addr_a;
            base_b    <= cfg_addr_b;
            ptr_res   <= cfg_addr_res;
            if (cfg_bad) begin
              state <= FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state   <= CLR;
              acc_clr <= 1'b1;
            end
          end
        end

        CLR: begin
          state       <= RD;
          beats_left  <= k_beats - 12'd1;
          rem         <= cols_lat;
          mem_rd      <= 2'b11;
          mem_addr[0] <= ptr_a;
          mem_addr[1] <= base_b;
          ptr_a       <= ptr_a + AW'(1);
          ptr_b       <= base_b + AW'(1);
        end

        RD: begin
          // Enables lag the read by one cycle to match memory latency.
          lane_en <= beat_mask;
          rem     <= rem - 16'd32;
          if (beats_left == 12'd0) begin
            state <= DRAIN;
          end else begin
            beats_left  <= beats_left - 12'd1;
            mem_rd      <= 2'b11;
            mem_addr[0] <= ptr_a;
            mem_addr[1] <= ptr_b;
            ptr_a       <= ptr_a + AW'(1);
            ptr_b       <= ptr_b + AW'(1);
          end
        end

        DRAIN: begin
          state       <= WB;
          mem_wr      <= 2'b01;
          mem_addr[0] <= ptr_res;
          mem_be      <= 32'hFFFF_FFFF;
          ptr_res     <= ptr_res + AW'(1);
          rows_left   <= rows_left - 16'd1;
        end

        WB: begin
          if (rows_left == 16'd0) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state   <= CLR;
            acc_clr <= 1'b1;
          end
        end

        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef XLR_MAC_SEQ_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      perf_cnt <= '0;
    end else if (state == IDLE && go) begin
      perf_cnt <= '0;
    end else if (busy && perf_cnt != 32'hFFFF_FFFF) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_cycles = perf_cnt;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_xlr_mac_seq.sv
module tb_xlr_mac_seq;

  logic             clk;
  logic             sync_rst;
  logic             go;
  logic [15:0]      cfg_rows;
  logic [15:0]      cfg_cols;
  logic [3:0]       cfg_addr_a;
  logic [3:0]       cfg_addr_b;
  logic [3:0]       cfg_addr_res;
  logic [1:0][3:0]  mem_addr;
  logic [1:0]       mem_rd;
  logic [1:0]       mem_wr;
  logic [31:0]      mem_be;
  logic             acc_clr;
  logic [7:0]       lane_en;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      perf_cycles;

`ifdef XLR_MAC_SEQ_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  xlr_mac_seq #(
    .LOG2_LINES_PER_MEM(4),
    .NUM_LANES(8)
  ) dut (
    .clk(clk),
    .sync_rst(sync_rst),
    .go(go),
    .cfg_rows(cfg_rows),
    .cfg_cols(cfg_cols),
    .cfg_addr_a(cfg_addr_a),
    .cfg_addr_b(cfg_addr_b),
    .cfg_addr_res(cfg_addr_res),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_be(mem_be),
    .acc_clr(acc_clr),
    .lane_en(lane_en),
    .busy(busy),
    .done(done),
    .err(err),
    .perf_cycles(perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected output vector per clock cycle.
  typedef struct packed {
    logic       acc_clr;
    logic [7:0] lane;
    logic [1:0] rd;
    logic [1:0] wr;
    logic [3:0] a0;
    logic [3:0] a1;
    logic       be_on;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors;
  int          miscompares;
  bit          chk_en;
  bit          cur_busy;
  logic [31:0] perf_m;

  function automatic logic [7:0] lane_mask(input int cols, input int bt);
    logic [7:0] r;
    int m;
    m = cols - 32 * bt;
    if (m > 32) m = 32;
    r = '0;
    for (int i = 0; i < 8; i++) if (4 * i < m) r[i] = 1'b1;
    return r;
  endfunction

  // Whole-operation trace built from the row/beat rules.
  task automatic push_run(input int rows, input int cols, input int a, input int b, input int res);
    exp_t e;
    int k;
    if (rows == 0 || cols == 0) begin
      e = '0; e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1;
      exp_q.push_back(e);
      return;
    end
    k = (cols + 31) / 32;
    for (int r = 0; r < rows; r++) begin
      e = '0; e.busy = 1'b1; e.acc_clr = 1'b1;
      exp_q.push_back(e);
      for (int bt = 0; bt < k; bt++) begin
        e = '0; e.busy = 1'b1; e.rd = 2'b11;
        e.a0 = 4'((a + r * k + bt) & 15);
        e.a1 = 4'((b + bt) & 15);
        if (bt > 0) e.lane = lane_mask(cols, bt - 1);
        exp_q.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.lane = lane_mask(cols, k - 1);
      exp_q.push_back(e);
      e = '0; e.busy = 1'b1; e.wr = 2'b01; e.be_on = 1'b1;
      e.a0 = 4'((res + r) & 15);
      exp_q.push_back(e);
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Model: observes the same sampled inputs as the DUT.
  always @(posedge clk) begin
    if (sync_rst) begin
      exp_q.delete();
      perf_m = '0;
    end else if (go && !cur_busy) begin
      push_run(int'(cfg_rows), int'(cfg_cols), int'(cfg_addr_a), int'(cfg_addr_b), int'(cfg_addr_res));
      perf_m = '0;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin : cmp
    exp_t e;
    logic bad;
    if (chk_en) begin
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      bad = 1'b0;
      if (acc_clr !== e.acc_clr || lane_en !== e.lane || mem_rd !== e.rd || mem_wr !== e.wr ||
          busy !== e.busy || done !== e.done || err !== e.err) bad = 1'b1;
      if ((e.rd[0] || e.wr[0]) && mem_addr[0] !== e.a0) bad = 1'b1;
      if (e.rd[1] && mem_addr[1] !== e.a1) bad = 1'b1;
      if (e.be_on && mem_be !== 32'hFFFF_FFFF) bad = 1'b1;
      if (perf_cycles !== perf_m) bad = 1'b1;
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t got clr=%b lane=%h rd=%b wr=%b a0=%0d a1=%0d be=%h busy=%b done=%b err=%b perf=%0d | exp clr=%b lane=%h rd=%b wr=%b a0=%0d a1=%0d busy=%b done=%b err=%b perf=%0d",
                 $time, acc_clr, lane_en, mem_rd, mem_wr, mem_addr[0], mem_addr[1], mem_be, busy, done, err, perf_cycles,
                 e.acc_clr, e.lane, e.rd, e.wr, e.a0, e.a1, e.busy, e.done, e.err, perf_m);
      end
      cur_busy = e.busy;
      if (PERF_EN && e.busy) perf_m = perf_m + 32'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s got %0h exp %0h", nm, got, expv);
    end
  endtask

  task automatic set_cfg(input int r, input int c, input int a, input int b, input int res);
    cfg_rows     = 16'(r);
    cfg_cols     = 16'(c);
    cfg_addr_a   = 4'(a);
    cfg_addr_b   = 4'(b);
    cfg_addr_res = 4'(res);
  endtask

  task automatic go_run(input int r, input int c, input int a, input int b, input int res);
    set_cfg(r, c, a, b, res);
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      miscompares++;
      $display("FAIL wait_idle got busy=%b exp idle within 400 cycles", busy);
    end
  endtask

  initial begin : drv
    logic [7:0] lanes[$];
    logic [3:0] wrs[$];
    int n;
    vectors = 0;
    miscompares = 0;
    chk_en = 1'b0;
    cur_busy = 1'b0;
    perf_m = '0;
    sync_rst = 1'b1;
    go = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_perf", perf_cycles, 32'd0);
    sync_rst = 1'b0;
    tick();

    // rows=1 cols=32 a=2 b=5 res=9
    go_run(1, 32, 2, 5, 9);
    chk("t1_clr", 32'(acc_clr), 32'd1);
    tick();
    chk("t1_rd", 32'(mem_rd), 32'd3);
    chk("t1_a0", 32'(mem_addr[0]), 32'd2);
    chk("t1_a1", 32'(mem_addr[1]), 32'd5);
    tick();
    chk("t1_lane", 32'(lane_en), 32'hFF);
    tick();
    chk("t1_wr", 32'(mem_wr), 32'd1);
    chk("t1_wa", 32'(mem_addr[0]), 32'd9);
    chk("t1_be", mem_be, 32'hFFFF_FFFF);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_err", 32'(err), 32'd0);
    tick();
    chk("t1_idle", 32'(busy), 32'd0);
    tick();

    // rows=2 cols=40: k=2, 11 busy cycles
    go_run(2, 40, 0, 0, 4);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b1) n++;
      if (lane_en != 8'h00) lanes.push_back(lane_en);
      if (mem_wr[0] === 1'b1) wrs.push_back(mem_addr[0]);
      if (busy === 1'b0 && n > 0) break;
      tick();
    end
    chk("t2_busy_cycles", 32'(n), 32'd11);
    chk("t2_lane_cnt", 32'(lanes.size()), 32'd4);
    if (lanes.size() == 4) begin
      chk("t2_lane0", 32'(lanes[0]), 32'hFF);
      chk("t2_lane1", 32'(lanes[1]), 32'h03);
      chk("t2_lane2", 32'(lanes[2]), 32'hFF);
      chk("t2_lane3", 32'(lanes[3]), 32'h03);
    end
    chk("t2_wr_cnt", 32'(wrs.size()), 32'd2);
    if (wrs.size() == 2) begin
      chk("t2_wr0", 32'(wrs[0]), 32'd4);
      chk("t2_wr1", 32'(wrs[1]), 32'd5);
    end
    chk("t2_perf", perf_cycles, PERF_EN ? 32'd11 : 32'd0);
    tick();

    // config errors
    go_run(0, 10, 1, 1, 1);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_err", 32'(err), 32'd1);
    tick();
    chk("t3_idle", 32'(busy), 32'd0);
    go_run(3, 0, 1, 1, 1);
    chk("t3b_err", 32'(err), 32'd1);
    tick();
    tick();

    // address wrap
    go_run(1, 64, 15, 15, 0);
    tick();
    chk("t4_a0_b0", 32'(mem_addr[0]), 32'd15);
    chk("t4_a1_b0", 32'(mem_addr[1]), 32'd15);
    tick();
    chk("t4_a0_b1", 32'(mem_addr[0]), 32'd0);
    chk("t4_a1_b1", 32'(mem_addr[1]), 32'd0);
    wait_idle();
    tick();

    // abort during second RD beat, go alongside reset is ignored
    go_run(1, 64, 3, 7, 2);
    tick();
    tick();
    sync_rst = 1'b1;
    go = 1'b1;
    tick();
    sync_rst = 1'b0;
    go = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rd", 32'(mem_rd), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    tick();
    tick();
    chk("t5_still_idle", 32'(busy), 32'd0);
    go_run(1, 64, 3, 7, 2);
    tick();
    set_cfg(2, 200, 9, 9, 9);
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_idle();
    tick();

    // go in FIN ignored, go in first IDLE cycle accepted
    go_run(1, 32, 1, 1, 1);
    repeat (4) tick();
    chk("t6_fin", 32'(done), 32'd1);
    set_cfg(1, 32, 4, 4, 4);
    go = 1'b1;
    tick();
    chk("t6_idle", 32'(busy), 32'd0);
    tick();
    go = 1'b0;
    chk("t6_accept", 32'(acc_clr), 32'd1);
    wait_idle();
    tick();

    // randomized runs with stray go pulses and occasional resets
    for (int run = 0; run < 40; run++) begin
      int r, c, sel;
      sel = int'($urandom_range(0, 9));
      c = (sel == 0) ? 0 : (sel < 5) ? int'($urandom_range(1, 64)) : int'($urandom_range(65, 300));
      r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
      go_run(r, c, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      for (int j = 0; j < 20; j++) begin
        go = ($urandom_range(0, 7) == 0);
        if (go) set_cfg(int'($urandom_range(0, 2)), int'($urandom_range(0, 100)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        sync_rst = ($urandom_range(0, 49) == 0);
        tick();
      end
      go = 1'b0;
      sync_rst = 1'b0;
      wait_idle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
